// File: rtl/alu_pipe_if.sv
// Operand/result bus between the operand sequencer, alu_pipe and writeback.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid/in_ready  operand beat handshake
//   a, b, op           operands and opcode (op: ADD SUB AND OR XOR NOTA INCA DECA)
//   acc_sel, acc_clr   use accumulator as operand A / clear accumulator
//   out_valid/out_ready result handshake
//   result, flag_c/z/n/v registered result and flags
//   acc                current accumulator value
// Modports: slave = the ALU, master = the driver of operands / consumer of results.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_sel;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic [WIDTH-1:0] acc;

    modport slave (
        input  in_valid, a, b, op, acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, acc
    );

    modport master (
        output in_valid, a, b, op, acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, acc
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with C/Z/N/V flags and an accumulator usable as operand A.
// Latency: 1 cycle from accepted operand beat to out_valid; 1 beat/cycle while out_ready=1.
// Backpressure: in_ready = !out_valid | out_ready; result/flags hold while stalled.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (clears result, flags, out_valid, acc)
//   bus  alu_pipe_if.slave (operand handshake, result handshake, flags, acc)
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] result_q;
    logic             c_q, z_q, n_q, v_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] acc_q;

    logic             in_fire;
    logic             out_fire;

    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   sum;
    logic             is_add;
    logic             is_sub;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    // in_ready depends only on the output register state, never on in_valid.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;

    always_comb begin
        opnd_a = bus.acc_sel ? acc_q : bus.a;
        opnd_b = bus.b;
        sum    = '0;
        is_add = 1'b0;
        is_sub = 1'b0;
        res    = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;

        case (bus.op)
            OP_ADD: is_add = 1'b1;
            OP_SUB: is_sub = 1'b1;
            OP_INC: begin
                is_add = 1'b1;
                opnd_b = ONE;
            end
            OP_DEC: begin
                is_sub = 1'b1;
                opnd_b = ONE;
            end
            OP_AND: res = opnd_a & opnd_b;
            OP_OR:  res = opnd_a | opnd_b;
            OP_XOR: res = opnd_a ^ opnd_b;
            OP_NOT: res = ~opnd_a;
            default: res = '0;
        endcase

        // Zero-extended WIDTH+1 arithmetic: for subtraction the top bit is the
        // borrow, i.e. set exactly when A < B unsigned.
        if (is_add) begin
            sum   = {1'b0, opnd_a} + {1'b0, opnd_b};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (opnd_a[WIDTH-1] == opnd_b[WIDTH-1]) &&
                    (res[WIDTH-1] != opnd_a[WIDTH-1]);
        end else if (is_sub) begin
            sum   = {1'b0, opnd_a} - {1'b0, opnd_b};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (opnd_a[WIDTH-1] != opnd_b[WIDTH-1]) &&
                    (res[WIDTH-1] != opnd_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            // A new beat on the same edge as out_fire replaces the old result
            // and keeps out_valid high.
            if (in_fire) begin
                result_q    <= res;
                c_q         <= res_c;
                z_q         <= (res == '0);
                n_q         <= res[WIDTH-1];
                v_q         <= res_v;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            // Clear wins over load; the concurrent beat already used the old acc.
            if (bus.acc_clr) begin
                acc_q <= '0;
            end else if (in_fire && bus.acc_sel) begin
                acc_q <= res;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_v    = v_q;
    assign bus.acc       = acc_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8) with an expected-result queue.
// Latency: checks one-cycle result latency and stall/resume behaviour.
// Backpressure: drives out_ready low/high to exercise stalls.
module tb_alu_pipe;
    localparam int W = 8;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] NOT = 3'b101;
    localparam logic [2:0] INC = 3'b110;
    localparam logic [2:0] DEC = 3'b111;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int pops     = 0;
    logic [11:0] sb[$];      // {c, z, n, v, result}
    logic [7:0]  acc_m = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model on signed/unsigned integers, independent of bit tricks.
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ua, ub, sa, sb_i, r, sr;
        logic c, v;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        if (op == INC || op == DEC) ub = 1;
        sa   = (ua >= 128) ? ua - 256 : ua;
        sb_i = (ub >= 128) ? ub - 256 : ub;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            ADD, INC: begin
                r  = ua + ub;
                c  = (r > 255);
                sr = sa + sb_i;
                v  = (sr > 127) || (sr < -128);
            end
            SUB, DEC: begin
                r  = ua - ub;
                c  = (ua < ub);
                sr = sa - sb_i;
                v  = (sr > 127) || (sr < -128);
            end
            AND: r = int'(a & b);
            OR:  r = int'(a | b);
            XOR: r = int'(a ^ b);
            default: r = int'(~a);
        endcase
        res = r[7:0];
        return {c, (res == 8'h00), res[7], v, res};
    endfunction

    function automatic logic [11:0] observed();
        return {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v, bus.result};
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic sel, input logic clr);
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.acc_sel  = sel;
        bus.acc_clr  = clr;
    endtask

    // One clock: pop/compare on output handshake, push model on input handshake.
    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", 32'(bus.out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_result", 32'(observed()), 32'(e));
                pops++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e = model(bus.op, bus.acc_sel ? acc_m : bus.a, bus.b);
            sb.push_back(e);
            if (bus.acc_sel) acc_m = e[7:0];
        end
        if (bus.acc_clr) acc_m = 8'h00;
        @(posedge clk);
        #1;
        chk("acc_track", 32'(bus.acc), 32'(acc_m));
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] exp;
    } vec_t;

    vec_t stream[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;

        stream[0] = '{op: AND, a: 8'hA5, b: 8'h0F, exp: 12'h005};
        stream[1] = '{op: OR,  a: 8'hA0, b: 8'h05, exp: 12'h2A5};
        stream[2] = '{op: XOR, a: 8'hFF, b: 8'h0F, exp: 12'h2F0};
        stream[3] = '{op: NOT, a: 8'h0F, b: 8'h00, exp: 12'h2F0};
        stream[4] = '{op: INC, a: 8'hFF, b: 8'h00, exp: 12'hC00};
        stream[5] = '{op: DEC, a: 8'h00, b: 8'h00, exp: 12'hAFF};
        stream[6] = '{op: INC, a: 8'h7F, b: 8'h00, exp: 12'h380};
        stream[7] = '{op: DEC, a: 8'h80, b: 8'h00, exp: 12'h17F};

        // Reset state
        rst = 1'b1;
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result_flags", 32'(observed()), 32'd0);
        chk("rst_acc", 32'(bus.acc), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD FF+01 wraps to 00 with carry; one-cycle latency
        drive(1'b1, ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_add_ff_01", 32'(observed()), 32'hC00);

        // SUB overflow and SUB borrow
        drive(1'b1, SUB, 8'h80, 8'h01, 1'b0, 1'b0);
        tick();
        chk("t2_sub_80_01", 32'(observed()), 32'h17F);
        drive(1'b1, SUB, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        chk("t2_sub_01_02", 32'(observed()), 32'hAFF);
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("t2_drained", 32'(bus.out_valid), 32'd0);

        // Back-pressure: 3C held while out_ready=0
        bus.out_ready = 1'b0;
        drive(1'b1, AND, 8'h3C, 8'hFF, 1'b0, 1'b0);
        tick();
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_result", 32'(bus.result), 32'h3C);
        drive(1'b1, XOR, 8'h0F, 8'hF0, 1'b0, 1'b0);
        #1;
        chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        chk("t3_hold_result", 32'(bus.result), 32'h3C);
        chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("t3_in_ready_high", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t3_next_result", 32'(bus.result), 32'hFF);
        chk("t3_next_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("t3_drained", 32'(bus.out_valid), 32'd0);

        // Accumulator running sum, then clear with simultaneous beat
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b1, ADD, 8'h00, 8'h05, 1'b1, 1'b0);
        tick();
        chk("t4_sum1", 32'(bus.result), 32'h05);
        tick();
        chk("t4_sum2", 32'(bus.result), 32'h0A);
        tick();
        chk("t4_sum3", 32'(bus.result), 32'h0F);
        chk("t4_acc_0f", 32'(bus.acc), 32'h0F);
        drive(1'b1, ADD, 8'h00, 8'h01, 1'b1, 1'b1);
        tick();
        chk("t4_clr_result", 32'(bus.result), 32'h10);
        chk("t4_clr_acc", 32'(bus.acc), 32'h00);
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();

        // Back-to-back stream including wrap-around and overflow cases
        pops0 = pops;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, stream[i].op, stream[i].a, stream[i].b, 1'b0, 1'b0);
            tick();
            chk($sformatf("t5_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("t5_out_%0d", i), 32'(observed()), 32'(stream[i].exp));
        end
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("t5_pop_count", 32'(pops - pops0), 32'd8);
        chk("t5_drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with a pending result and non-zero acc
        bus.out_ready = 1'b0;
        drive(1'b1, ADD, 8'h10, 8'h20, 1'b1, 1'b0);
        tick();
        chk("t6_pre_acc", 32'(bus.acc), 32'h20);
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_result_flags", 32'(observed()), 32'd0);
        chk("t6_acc", 32'(bus.acc), 32'd0);
        sb.delete();
        acc_m = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Post-reset beat
        drive(1'b1, ADD, 8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        chk("t7_result", 32'(observed()), 32'h002);
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
